// File: rtl/move_pkg.sv
// Shared types and constants for the character movement controller:
// state encoding, sprite_control field layout and default geometry.
package move_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MOVING  = 2'b01,
    ST_FALLING = 2'b10,
    ST_JUMPING = 2'b11
  } move_state_t;

  localparam int POS_W        = 10;
  localparam int SC_W         = 7;
  localparam int SC_DIR_BIT   = 6;
  localparam int SC_AIR_BIT   = 5;
  localparam int SC_IDLE_BIT  = 4;
  localparam int SC_FRAME_LSB = 0;
  localparam int SC_FRAME_W   = 4;

  localparam int DEF_SPAWN_X  = 500;
  localparam int DEF_SPAWN_Y  = 698;
  localparam int DEF_CHAR_W   = 64;
  localparam int DEF_CHAR_H   = 68;
  localparam int DEF_SCREEN_W = 1024;
  localparam int DEF_FLOOR_Y  = 766;

  function automatic logic [SC_W-1:0] pack_sprite(
    input logic                  dir_right,
    input logic                  airborne,
    input logic                  idle,
    input logic [SC_FRAME_W-1:0] frame
  );
    logic [SC_W-1:0] v;
    v                                = '0;
    v[SC_DIR_BIT]                    = dir_right;
    v[SC_AIR_BIT]                    = airborne;
    v[SC_IDLE_BIT]                   = idle;
    v[SC_FRAME_LSB +: SC_FRAME_W]    = frame;
    return v;
  endfunction

endpackage

// File: rtl/move_div_counter.sv
// Rate divider: while running, counts cycles and pulses o_step on the last
// count of each period of i_div cycles. Stops and clears when not running.
module move_div_counter #(
  parameter int CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_step
);

  logic [CNT_W-1:0] r_cnt;

  // >= rather than == so a divider that shrinks mid-period cannot strand the count
  assign o_step = i_en && i_run && (r_cnt >= i_div - 1'b1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (!i_run || o_step) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/char_move_ctrl.sv
// Player-character movement controller: turns left/right/jump requests and
// external collision flags into registered x/y, state and sprite control.
module char_move_ctrl
  import move_pkg::*;
#(
  parameter int SPAWN_X        = DEF_SPAWN_X,
  parameter int SPAWN_Y        = DEF_SPAWN_Y,
  parameter int CHAR_W         = DEF_CHAR_W,
  parameter int CHAR_H         = DEF_CHAR_H,
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int FLOOR_Y        = DEF_FLOOR_Y,
  parameter int CNT_W          = 20,
  parameter int WALK_DIV       = 350000,
  parameter int AIR_DIV        = 650000,
  parameter int JUMP_HEIGHT    = 200,
  parameter int JUMP_SLOW_ZONE = 25,
  parameter int JUMP_DIV_START = 200000,
  parameter int JUMP_DIV_MAX   = 800000,
  parameter int FALL_DIV_START = 800000,
  parameter int FALL_DIV_MIN   = 150000,
  parameter int ACCEL_STEP     = 20000,
  parameter int ANIM_FRAMES    = 8,
  parameter int ANIM_PX        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             respawn,
  input  logic             left,
  input  logic             right,
  input  logic             jump,
  input  logic             on_ground,
  input  logic             hit_ceiling,
  input  logic             blocked_left,
  input  logic             blocked_right,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic [SC_W-1:0]  sprite_control,
  output logic [1:0]       state_o,
  output logic             landed
);

  localparam int CW1  = CNT_W + 1;
  localparam int PX_W = (ANIM_PX > 1) ? $clog2(ANIM_PX) : 1;

  localparam logic [POS_W-1:0] X_SPAWN  = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0] Y_SPAWN  = POS_W'(SPAWN_Y);
  localparam logic [POS_W-1:0] X_MAX    = POS_W'(SCREEN_W - CHAR_W);
  localparam logic [POS_W-1:0] Y_GROUND = POS_W'(FLOOR_Y - CHAR_H);
  localparam logic [POS_W:0]   RISE_MAX  = (POS_W+1)'(JUMP_HEIGHT);
  localparam logic [POS_W:0]   RISE_FAST = (POS_W+1)'(JUMP_HEIGHT - JUMP_SLOW_ZONE);

  localparam logic [CNT_W-1:0] D_WALK  = CNT_W'(WALK_DIV);
  localparam logic [CNT_W-1:0] D_AIR   = CNT_W'(AIR_DIV);
  localparam logic [CNT_W-1:0] D_JSTRT = CNT_W'(JUMP_DIV_START);
  localparam logic [CNT_W-1:0] D_JMAX  = CNT_W'(JUMP_DIV_MAX);
  localparam logic [CNT_W-1:0] D_FSTRT = CNT_W'(FALL_DIV_START);
  localparam logic [CNT_W-1:0] D_FMIN  = CNT_W'(FALL_DIV_MIN);
  localparam logic [CNT_W-1:0] D_ACC   = CNT_W'(ACCEL_STEP);
  localparam logic [CW1-1:0]   D_FLOOR = CW1'(FALL_DIV_MIN + ACCEL_STEP);

  localparam logic [PX_W-1:0]       PX_LAST    = PX_W'(ANIM_PX - 1);
  localparam logic [SC_FRAME_W-1:0] FRAME_LAST = SC_FRAME_W'(ANIM_FRAMES - 1);

  move_state_t             r_state, w_next;
  logic [POS_W-1:0]        r_x, r_y, r_y_start;
  logic [CNT_W-1:0]        r_asc_div, r_desc_div;
  logic [PX_W-1:0]         r_pxcnt, w_pxcnt_nxt;
  logic [SC_FRAME_W-1:0]   r_frame, w_frame_nxt;
  logic                    r_dir_right, r_air, r_idle, r_landed;
  logic                    w_dir_right_nxt, w_air_nxt, w_idle_nxt, w_landed_nxt;

  logic                    w_dir_r, w_dir_l, w_dir_any, w_grounded, w_state_chg;
  logic                    w_hstep, w_vstep, w_vrun, w_x_move;
  logic                    w_jump_go, w_jump_end, w_slow_zone;
  logic [CNT_W-1:0]        w_hdiv, w_vdiv;
  logic [CW1-1:0]          w_asc_sum;

  assign w_dir_r    = right & ~left;
  assign w_dir_l    = left & ~right;
  assign w_dir_any  = w_dir_r | w_dir_l;
  assign w_grounded = on_ground | (r_y == Y_GROUND);
  assign w_jump_go  = jump & w_grounded;
  assign w_jump_end = (({1'b0, r_y} + RISE_MAX) <= {1'b0, r_y_start}) | hit_ceiling | (r_y == '0);
  assign w_slow_zone = ({1'b0, r_y - 1'b1} + RISE_FAST) <= {1'b0, r_y_start};
  assign w_state_chg = (w_next != r_state);

  assign w_hdiv = ((r_state == ST_IDLE) || (r_state == ST_MOVING)) ? D_WALK : D_AIR;
  assign w_vdiv = (r_state == ST_JUMPING) ? r_asc_div : r_desc_div;
  // vertical motion pauses on any transition cycle so the exit position is exact
  assign w_vrun = ((r_state == ST_JUMPING) ||
                   ((r_state == ST_FALLING) && (r_y < Y_GROUND))) && !w_state_chg;

  move_div_counter #(.CNT_W(CNT_W)) u_hdiv (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (enable),
    .i_clr   (respawn),
    .i_run   (w_dir_any),
    .i_div   (w_hdiv),
    .o_step  (w_hstep)
  );

  move_div_counter #(.CNT_W(CNT_W)) u_vdiv (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (enable),
    .i_clr   (respawn | (enable & w_state_chg)),
    .i_run   (w_vrun),
    .i_div   (w_vdiv),
    .o_step  (w_vstep)
  );

  assign w_x_move = w_hstep &&
                    ((w_dir_r && !blocked_right && (r_x < X_MAX)) ||
                     (w_dir_l && !blocked_left  && (r_x != '0)));
  assign w_asc_sum = {1'b0, r_asc_div} + {1'b0, D_ACC};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_jump_go)        w_next = ST_JUMPING;
        else if (w_dir_any)   w_next = ST_MOVING;
        else if (!w_grounded) w_next = ST_FALLING;
      end
      ST_MOVING: begin
        if (w_jump_go)        w_next = ST_JUMPING;
        else if (!w_grounded) w_next = ST_FALLING;
        else if (!w_dir_any)  w_next = ST_IDLE;
      end
      ST_JUMPING: if (w_jump_end) w_next = ST_FALLING;
      ST_FALLING: if (w_grounded) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_air_nxt       = (w_next == ST_JUMPING) || (w_next == ST_FALLING);
    w_idle_nxt      = (w_next == ST_IDLE);
    w_landed_nxt    = (r_state == ST_FALLING) && (w_next == ST_IDLE);
    w_dir_right_nxt = r_dir_right;
    if (w_dir_r)      w_dir_right_nxt = 1'b1;
    else if (w_dir_l) w_dir_right_nxt = 1'b0;
  end

  always_comb begin
    w_pxcnt_nxt = r_pxcnt;
    w_frame_nxt = r_frame;
    if (w_x_move) begin
      if (r_pxcnt == PX_LAST) begin
        w_pxcnt_nxt = '0;
        w_frame_nxt = (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
      end else begin
        w_pxcnt_nxt = r_pxcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_state <= ST_IDLE;
    else if (respawn)  r_state <= ST_IDLE;
    else if (enable)   r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || respawn) begin
      r_dir_right <= 1'b1;
      r_air       <= 1'b0;
      r_idle      <= 1'b1;
      r_landed    <= 1'b0;
    end else if (!enable) begin
      r_landed    <= 1'b0;
    end else begin
      r_dir_right <= w_dir_right_nxt;
      r_air       <= w_air_nxt;
      r_idle      <= w_idle_nxt;
      r_landed    <= w_landed_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || respawn) begin
      r_x        <= X_SPAWN;
      r_y        <= Y_SPAWN;
      r_y_start  <= Y_SPAWN;
      r_asc_div  <= D_JSTRT;
      r_desc_div <= D_FSTRT;
      r_pxcnt    <= '0;
      r_frame    <= '0;
    end else if (enable) begin
      r_pxcnt <= w_pxcnt_nxt;
      r_frame <= w_frame_nxt;
      if (w_x_move) r_x <= w_dir_r ? r_x + 1'b1 : r_x - 1'b1;

      if (w_vstep) r_y <= (r_state == ST_JUMPING) ? r_y - 1'b1 : r_y + 1'b1;

      if ((w_next == ST_JUMPING) && (r_state != ST_JUMPING)) begin
        r_y_start <= r_y;
        r_asc_div <= D_JSTRT;
      end else if (w_vstep && (r_state == ST_JUMPING) && w_slow_zone) begin
        r_asc_div <= (w_asc_sum >= {1'b0, D_JMAX}) ? D_JMAX : w_asc_sum[CNT_W-1:0];
      end

      if ((w_next == ST_FALLING) && (r_state != ST_FALLING)) begin
        r_desc_div <= D_FSTRT;
      end else if (w_vstep && (r_state == ST_FALLING)) begin
        r_desc_div <= ({1'b0, r_desc_div} < D_FLOOR) ? D_FMIN : r_desc_div - D_ACC;
      end
    end
  end

  assign x              = r_x;
  assign y              = r_y;
  assign state_o        = r_state;
  assign landed         = r_landed;
  assign sprite_control = pack_sprite(r_dir_right, r_air, r_idle, r_frame);

endmodule
